// File: rtl/icache_dataram_arbiter.sv
// icache_dataram_arbiter: shares the single-port icache data array between
// lookup reads and buffered linefill writes, with starvation and hazard guards.
module icache_dataram_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int TXNID_W    = 5,
    parameter int DATA_W     = 512,
    parameter int ENTRY_W    = 3,
    parameter int WBUF_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_vld,
    output logic               rd_rdy,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic [TXNID_W-1:0] rd_txnid,
    input  logic               lf_vld,
    output logic               lf_rdy,
    input  logic [ADDR_W-1:0]  lf_addr,
    input  logic [DATA_W-1:0]  lf_data,
    input  logic               lf_lineA,
    input  logic [ENTRY_W-1:0] lf_entry_idx,
    output logic               lf_done_vld,
    output logic               lf_done_lineA,
    output logic [ENTRY_W-1:0] lf_done_entry_idx,
    output logic               mem_en,
    output logic               mem_wr_en,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               rsp_vld,
    output logic [TXNID_W-1:0] rsp_txnid
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0]     buf_addr_q  [WBUF_DEPTH];
    logic [DATA_W-1:0]     buf_data_q  [WBUF_DEPTH];
    logic                  buf_linea_q [WBUF_DEPTH];
    logic [ENTRY_W-1:0]    buf_entry_q [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [STV_W-1:0]      starve_q, starve_d;

    logic                  lf_done_vld_q, lf_done_vld_d;
    logic                  lf_done_linea_q, lf_done_linea_d;
    logic [ENTRY_W-1:0]    lf_done_entry_q, lf_done_entry_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [TXNID_W-1:0]    rsp_txnid_q, rsp_txnid_d;

    logic full, nonempty, hazard, starved;
    logic push, wr_grant, rd_grant;

    // Arbitration: fills wait unless full, starved or blocking a same-line read.
    always_comb begin
        full     = &vld_q;
        nonempty = |vld_q;
        starved  = (starve_q == STV_W'(STARVE_MAX));
        hazard   = 1'b0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (vld_q[i] && (buf_addr_q[i] == rd_addr)) begin
                hazard = 1'b1;
            end
        end
        lf_rdy   = !full;
        rd_rdy   = !(nonempty && (full || starved || hazard));
        push     = lf_vld && lf_rdy;
        wr_grant = nonempty && (!rd_vld || !rd_rdy);
        rd_grant = !wr_grant && rd_vld && rd_rdy;
    end

    // Array port mux: at most one access per cycle, zeros when idle.
    always_comb begin
        mem_en    = wr_grant || rd_grant;
        mem_wr_en = wr_grant;
        mem_addr  = '0;
        mem_wdata = '0;
        if (wr_grant) begin
            mem_addr  = buf_addr_q[rptr_q];
            mem_wdata = buf_data_q[rptr_q];
        end else if (rd_grant) begin
            mem_addr  = rd_addr;
        end
    end

    // Next-state for buffer bookkeeping, starvation counter and responses.
    always_comb begin
        wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = wr_grant ? rptr_q + PTR_W'(1) : rptr_q;
        vld_d  = vld_q;
        if (wr_grant) begin
            vld_d[rptr_q] = 1'b0;
        end
        if (push) begin
            vld_d[wptr_q] = 1'b1;
        end
        starve_d = starve_q;
        if (wr_grant || !nonempty) begin
            starve_d = '0;
        end else if (rd_grant && !starved) begin
            starve_d = starve_q + STV_W'(1);
        end
        lf_done_vld_d   = wr_grant;
        lf_done_linea_d = wr_grant ? buf_linea_q[rptr_q] : lf_done_linea_q;
        lf_done_entry_d = wr_grant ? buf_entry_q[rptr_q] : lf_done_entry_q;
        rsp_vld_d       = rd_grant;
        rsp_txnid_d     = rd_grant ? rd_txnid : rsp_txnid_q;
    end

    // Control state; reset drops any buffered fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q           <= '0;
            wptr_q          <= '0;
            rptr_q          <= '0;
            starve_q        <= '0;
            lf_done_vld_q   <= 1'b0;
            lf_done_linea_q <= 1'b0;
            lf_done_entry_q <= '0;
            rsp_vld_q       <= 1'b0;
            rsp_txnid_q     <= '0;
        end else begin
            vld_q           <= vld_d;
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            starve_q        <= starve_d;
            lf_done_vld_q   <= lf_done_vld_d;
            lf_done_linea_q <= lf_done_linea_d;
            lf_done_entry_q <= lf_done_entry_d;
            rsp_vld_q       <= rsp_vld_d;
            rsp_txnid_q     <= rsp_txnid_d;
        end
    end

    // Fill payload storage, qualified by the valid bits so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wptr_q]  <= lf_addr;
            buf_data_q[wptr_q]  <= lf_data;
            buf_linea_q[wptr_q] <= lf_lineA;
            buf_entry_q[wptr_q] <= lf_entry_idx;
        end
    end

    assign lf_done_vld       = lf_done_vld_q;
    assign lf_done_lineA     = lf_done_linea_q;
    assign lf_done_entry_idx = lf_done_entry_q;
    assign rsp_vld           = rsp_vld_q;
    assign rsp_txnid         = rsp_txnid_q;

endmodule
